mandelbrot_pixel_scheduler: RTL and testbench

Upstream frame sequencer for one Mandelbrot iteration core. It walks a width x height pixel grid in raster order and generates each pixel's Q8.24 coordinate incrementally. For each pixel it issues a start to the core, waits for the core's done, and emits the iteration count as a valid/ready pixel stream with start-of-frame and end-of-line markers.

---
 rtl/mandelbrot_pkg.sv | 29 ++
 rtl/mandelbrot_coord_stepper.sv | 68 ++++++
 rtl/mandelbrot_pixel_scheduler.sv | 159 +++++++++++++++
 tb/tb_mandelbrot_pixel_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot pixel scheduler and its
// coordinate stepper.
package mandelbrot_pkg;

    localparam int INTEGER_BITS    = 8;
    localparam int FRACTIONAL_BITS = 24;
    localparam int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS;
    localparam int MAX_ITER_WIDTH  = 16;
    localparam int DIM_WIDTH       = 12;

    typedef logic signed [DATA_WIDTH-1:0] coord_t;
    typedef logic [MAX_ITER_WIDTH-1:0]    iter_t;
    typedef logic [DIM_WIDTH-1:0]         dim_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_GUARD = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4,
        ST_FIN   = 3'd5
    } sched_state_e;

    // True when idx is the final index of a range of size limit (limit >= 1).
    function automatic logic dim_is_last(input dim_t idx, input dim_t limit);
        return idx == (limit - dim_t'(1));
    endfunction

endpackage

// File: rtl/mandelbrot_coord_stepper.sv
// Raster-order column/row counters with incremental x/y coordinate
// accumulators; configuration is captured on load.
module mandelbrot_coord_stepper
    import mandelbrot_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   i_load,
    input  logic   i_step,
    input  logic   i_wrap,
    input  dim_t   i_width,
    input  dim_t   i_height,
    input  coord_t i_x_start,
    input  coord_t i_y_start,
    input  coord_t i_dx,
    input  coord_t i_dy,
    output coord_t o_x,
    output coord_t o_y,
    output logic   o_last_col,
    output logic   o_last_row,
    output logic   o_first_pix
);

    dim_t   r_col, r_row, r_width, r_height;
    coord_t r_x, r_y, r_x_start, r_dx, r_dy;

    // Counter and accumulator update; additions wrap silently.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_col     <= '0;
            r_row     <= '0;
            r_width   <= '0;
            r_height  <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_x_start <= '0;
            r_dx      <= '0;
            r_dy      <= '0;
        end else if (i_load) begin
            r_col     <= '0;
            r_row     <= '0;
            r_width   <= i_width;
            r_height  <= i_height;
            r_x       <= i_x_start;
            r_y       <= i_y_start;
            r_x_start <= i_x_start;
            r_dx      <= i_dx;
            r_dy      <= i_dy;
        end else if (i_step) begin
            r_col <= r_col + dim_t'(1);
            r_x   <= r_x + r_dx;
        end else if (i_wrap) begin
            r_col <= '0;
            r_row <= r_row + dim_t'(1);
            r_x   <= r_x_start;
            r_y   <= r_y + r_dy;
        end else begin
            r_col <= r_col;
        end
    end

    assign o_x         = r_x;
    assign o_y         = r_y;
    assign o_last_col  = dim_is_last(r_col, r_width);
    assign o_last_row  = dim_is_last(r_row, r_height);
    assign o_first_pix = (r_col == dim_t'(0)) && (r_row == dim_t'(0));

endmodule

// File: rtl/mandelbrot_pixel_scheduler.sv
// Frame sequencer: issues one core start per pixel in raster order and
// streams each iteration count out with start-of-frame / end-of-line marks.
module mandelbrot_pixel_scheduler #(
    parameter int INTEGER_BITS    = 8,
    parameter int FRACTIONAL_BITS = 24,
    parameter int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS,
    parameter int MAX_ITER_WIDTH  = 16,
    parameter int DIM_WIDTH       = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      frame_start_i,
    input  logic [DIM_WIDTH-1:0]      width_i,
    input  logic [DIM_WIDTH-1:0]      height_i,
    input  logic [DATA_WIDTH-1:0]     x_start_i,
    input  logic [DATA_WIDTH-1:0]     y_start_i,
    input  logic [DATA_WIDTH-1:0]     dx_i,
    input  logic [DATA_WIDTH-1:0]     dy_i,
    input  logic [MAX_ITER_WIDTH-1:0] max_iter_i,
    output logic                      busy_o,
    output logic                      frame_done_o,
    output logic                      core_start_o,
    output logic [DATA_WIDTH-1:0]     core_x0_o,
    output logic [DATA_WIDTH-1:0]     core_y0_o,
    output logic [MAX_ITER_WIDTH-1:0] core_max_iter_o,
    input  logic [MAX_ITER_WIDTH-1:0] core_iter_i,
    input  logic                      core_done_i,
    output logic [MAX_ITER_WIDTH-1:0] m_tdata_o,
    output logic                      m_tvalid_o,
    input  logic                      m_tready_i,
    output logic                      m_tlast_o,
    output logic                      m_tuser_o
);
    import mandelbrot_pkg::*;

    sched_state_e r_state;
    logic         r_busy, r_frame_done, r_core_start, r_tvalid, r_tlast, r_tuser;
    iter_t        r_max_iter, r_tdata;
    coord_t       w_x, w_y;
    logic         w_last_col, w_last_row, w_first_pix;
    logic         w_accept, w_empty, w_handshake, w_step, w_wrap;

    assign w_accept    = (r_state == ST_IDLE) && frame_start_i;
    assign w_empty     = (width_i == {DIM_WIDTH{1'b0}}) || (height_i == {DIM_WIDTH{1'b0}});
    assign w_handshake = (r_state == ST_OUT) && m_tready_i;
    assign w_step      = w_handshake && !w_last_col;
    assign w_wrap      = w_handshake && w_last_col && !w_last_row;

    mandelbrot_coord_stepper u_stepper (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_load      (w_accept),
        .i_step      (w_step),
        .i_wrap      (w_wrap),
        .i_width     (width_i),
        .i_height    (height_i),
        .i_x_start   (x_start_i),
        .i_y_start   (y_start_i),
        .i_dx        (dx_i),
        .i_dy        (dy_i),
        .o_x         (w_x),
        .o_y         (w_y),
        .o_last_col  (w_last_col),
        .o_last_row  (w_last_row),
        .o_first_pix (w_first_pix)
    );

    // Scheduler FSM; every output is set on the transition into its state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_core_start <= 1'b0;
            r_max_iter   <= '0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_tuser      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (frame_start_i) begin
                        r_max_iter <= max_iter_i;
                        r_busy     <= 1'b1;
                        if (w_empty) begin
                            r_state      <= ST_FIN;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state      <= ST_ISSUE;
                            r_core_start <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_core_start <= 1'b0;
                    r_state      <= ST_GUARD;
                end
                // A done still high from the previous pixel is not sampled here.
                ST_GUARD: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done_i) begin
                        r_tdata  <= core_iter_i;
                        r_tvalid <= 1'b1;
                        r_tlast  <= w_last_col;
                        r_tuser  <= w_first_pix;
                        r_state  <= ST_OUT;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_OUT: begin
                    if (m_tready_i) begin
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                        r_tuser  <= 1'b0;
                        if (w_last_col && w_last_row) begin
                            r_state      <= ST_FIN;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state      <= ST_ISSUE;
                            r_core_start <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_OUT;
                    end
                end
                ST_FIN: begin
                    r_frame_done <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b0;
                    r_core_start <= 1'b0;
                    r_tvalid     <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o          = r_busy;
    assign frame_done_o    = r_frame_done;
    assign core_start_o    = r_core_start;
    assign core_x0_o       = w_x;
    assign core_y0_o       = w_y;
    assign core_max_iter_o = r_max_iter;
    assign m_tdata_o       = r_tdata;
    assign m_tvalid_o      = r_tvalid;
    assign m_tlast_o       = r_tlast;
    assign m_tuser_o       = r_tuser;

endmodule

// File: tb/tb_mandelbrot_pixel_scheduler.sv
// Randomised bench for mandelbrot_pixel_scheduler with a behavioural core
// responder and a closed-form raster model of the expected pixel stream.
module tb_mandelbrot_pixel_scheduler;
    import mandelbrot_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   frame_start = 1'b0;
    dim_t   cfg_w = '0, cfg_h = '0;
    coord_t cfg_xs = '0, cfg_ys = '0, cfg_dx = '0, cfg_dy = '0;
    iter_t  cfg_mi = '0;
    logic   busy, frame_done, core_start, m_tvalid, m_tlast, m_tuser;
    logic   m_tready = 1'b0;
    logic   core_done = 1'b0;
    iter_t  core_iter = '0;
    iter_t  core_mi, m_tdata;
    logic [31:0] core_x0, core_y0;

    always #5 clk = ~clk;

    mandelbrot_pixel_scheduler dut (
        .clk_i(clk), .rst_i(rst), .frame_start_i(frame_start),
        .width_i(cfg_w), .height_i(cfg_h), .x_start_i(cfg_xs), .y_start_i(cfg_ys),
        .dx_i(cfg_dx), .dy_i(cfg_dy), .max_iter_i(cfg_mi),
        .busy_o(busy), .frame_done_o(frame_done), .core_start_o(core_start),
        .core_x0_o(core_x0), .core_y0_o(core_y0), .core_max_iter_o(core_mi),
        .core_iter_i(core_iter), .core_done_i(core_done),
        .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
        .m_tlast_o(m_tlast), .m_tuser_o(m_tuser)
    );

    int tests_run = 0;
    int fails = 0;

    // Core model configuration
    int     core_lat = 2;
    bit     stale_mode = 1'b0;
    bit     colrow_mode = 1'b0;
    coord_t g_xs = '0, g_ys = '0;

    function automatic iter_t core_fn(input coord_t x, input coord_t y);
        coord_t ddx, ddy;
        ddx = x - g_xs;
        ddy = y - g_ys;
        if (colrow_mode) return iter_t'(ddx >>> 23) + iter_t'(ddy >>> 24);
        else return x[31:16] ^ y[15:0] ^ {x[7:0], y[23:16]};
    endfunction

    // Behavioural iteration core: done held until the next start, optionally stale for one extra cycle
    int     c_cnt = 0;
    bit     c_stale = 1'b0;
    coord_t c_x = '0, c_y = '0;
    always @(posedge clk) begin
        if (rst) begin
            c_cnt <= 0; c_stale <= 1'b0; core_done <= 1'b0; core_iter <= '0;
        end else if (core_start) begin
            c_x <= core_x0; c_y <= core_y0; c_cnt <= core_lat;
            if (stale_mode) c_stale <= 1'b1;
            else begin c_stale <= 1'b0; core_done <= 1'b0; end
        end else if (c_stale) begin
            c_stale <= 1'b0; core_done <= 1'b0;
        end else if (c_cnt > 0) begin
            c_cnt <= c_cnt - 1;
            if (c_cnt == 1) begin core_done <= 1'b1; core_iter <= core_fn(c_x, c_y); end
        end
    end

    // Observations of one frame
    iter_t  q_data[$];
    bit     q_last[$], q_user[$];
    coord_t q_x[$], q_y[$];
    int     n_done, n_stall_bad, n_start_bad, done_cycle;
    bit     timeout;

    // Reference model of the expected stream
    iter_t  e_data[$];
    bit     e_last[$], e_user[$];
    coord_t e_x[$], e_y[$];

    function automatic void build_model(input int w, input int h, input coord_t xs,
                                        input coord_t ys, input coord_t dx, input coord_t dy);
        coord_t x, y;
        e_data.delete(); e_last.delete(); e_user.delete(); e_x.delete(); e_y.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                x = xs + coord_t'(c) * dx;
                y = ys + coord_t'(r) * dy;
                e_x.push_back(x); e_y.push_back(y);
                e_data.push_back(core_fn(x, y));
                e_last.push_back(c == w - 1);
                e_user.push_back(c == 0 && r == 0);
            end
        end
    endfunction

    task automatic start_frame(input int w, input int h, input coord_t xs, input coord_t ys,
                               input coord_t dx, input coord_t dy, input iter_t mi);
        @(negedge clk);
        cfg_w = dim_t'(w); cfg_h = dim_t'(h); cfg_xs = xs; cfg_ys = ys;
        cfg_dx = dx; cfg_dy = dy; cfg_mi = mi; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        cfg_w = dim_t'($urandom); cfg_h = dim_t'($urandom); cfg_xs = $urandom; cfg_ys = $urandom;
        cfg_dx = $urandom; cfg_dy = $urandom; cfg_mi = iter_t'($urandom);
    endtask

    task automatic run_frame(input int stall_beat, input int ready_pct, input bit pulse_mid,
                             input int max_cycles);
        int    cyc = 0, stall_cnt = 0;
        bit    prev_stall = 1'b0, rdy, seen_done = 1'b0;
        iter_t s_data = '0;
        bit    s_last = 1'b0, s_user = 1'b0;
        q_data.delete(); q_last.delete(); q_user.delete(); q_x.delete(); q_y.delete();
        n_done = 0; n_stall_bad = 0; n_start_bad = 0; done_cycle = -1; timeout = 1'b0;
        forever begin
            if (core_start) begin
                q_x.push_back(core_x0); q_y.push_back(core_y0);
                if (m_tvalid) n_start_bad++;
            end
            if (frame_done) begin
                n_done++;
                if (!seen_done) done_cycle = cyc;
                seen_done = 1'b1;
            end
            if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== s_data ||
                               m_tlast !== s_last || m_tuser !== s_user)) n_stall_bad++;
            if (stall_beat == q_data.size() + 1 && m_tvalid && stall_cnt < 10) begin
                rdy = 1'b0; stall_cnt++;
            end else begin
                rdy = ($urandom_range(99) < ready_pct);
            end
            if (m_tvalid && rdy) begin
                q_data.push_back(m_tdata); q_last.push_back(m_tlast); q_user.push_back(m_tuser);
            end
            prev_stall = m_tvalid && !rdy;
            s_data = m_tdata; s_last = m_tlast; s_user = m_tuser;
            m_tready = rdy;
            frame_start = (pulse_mid && cyc == 7);
            if (seen_done && !busy) break;
            if (cyc >= max_cycles) begin timeout = 1'b1; break; end
            cyc++;
            @(negedge clk);
        end
        m_tready = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, frame_done, core_start, m_tvalid, m_tlast, m_tuser, core_x0, core_y0, core_mi, m_tdata} !== '0) begin
            fails++; $display("FAIL reset_hold: outputs=%0h required 0", {busy, frame_done, core_start, m_tvalid, m_tlast, m_tuser, core_x0, core_y0, core_mi, m_tdata});
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({busy, frame_done, core_start, m_tvalid} !== 4'b0) begin
            fails++; $display("FAIL reset_release: ctrl=%0b required 0", {busy, frame_done, core_start, m_tvalid});
        end
    endtask

    task automatic test_basic_frame();
        iter_t  exp_d[6];
        coord_t exp_x[3];
        exp_d = '{16'd0, 16'd1, 16'd2, 16'd1, 16'd2, 16'd3};
        exp_x = '{32'hFE000000, 32'hFE800000, 32'hFF000000};
        core_lat = 2; stale_mode = 1'b0; colrow_mode = 1'b1;
        g_xs = 32'hFE000000; g_ys = 32'hFF000000;
        start_frame(3, 2, 32'hFE000000, 32'hFF000000, 32'h00800000, 32'h01000000, 16'd100);
        run_frame(0, 100, 1'b0, 2000);
        colrow_mode = 1'b0;
        tests_run++;
        if (timeout || q_data.size() != 6) begin
            fails++; $display("FAIL basic_beats: got %0d beats timeout=%0b required 6", q_data.size(), timeout);
        end
        for (int i = 0; i < q_data.size() && i < 6; i++) begin
            tests_run++;
            if (q_data[i] !== exp_d[i] || q_last[i] !== (i == 2 || i == 5) || q_user[i] !== (i == 0)) begin
                fails++; $display("FAIL basic_beat%0d: data=%0d last=%0b user=%0b required %0d %0b %0b",
                                  i, q_data[i], q_last[i], q_user[i], exp_d[i], (i == 2 || i == 5), (i == 0));
            end
        end
        for (int i = 0; i < 3 && i < q_x.size(); i++) begin
            tests_run++;
            if (q_x[i] !== exp_x[i]) begin
                fails++; $display("FAIL basic_x0_%0d: got %0h required %0h", i, q_x[i], exp_x[i]);
            end
        end
        tests_run++;
        if (n_done != 1 || core_mi !== 16'd100) begin
            fails++; $display("FAIL basic_done: pulses=%0d max_iter=%0d required 1 100", n_done, core_mi);
        end
    endtask

    task automatic test_stream_frame(input string tag, input int w, input int h,
                                     input int stall_beat, input int ready_pct, input bit pulse_mid);
        coord_t xs, ys, dx, dy;
        xs = $urandom; ys = $urandom; dx = $urandom; dy = $urandom;
        build_model(w, h, xs, ys, dx, dy);
        start_frame(w, h, xs, ys, dx, dy, iter_t'($urandom));
        run_frame(stall_beat, ready_pct, pulse_mid, 4000);
        tests_run++;
        if (timeout || q_data.size() != e_data.size() || q_x.size() != e_x.size() || n_done != 1) begin
            fails++; $display("FAIL %s_counts: beats=%0d starts=%0d done=%0d timeout=%0b required %0d %0d 1 0",
                              tag, q_data.size(), q_x.size(), n_done, timeout, e_data.size(), e_x.size());
        end
        for (int i = 0; i < q_data.size() && i < e_data.size(); i++) begin
            tests_run++;
            if (q_data[i] !== e_data[i] || q_last[i] !== e_last[i] || q_user[i] !== e_user[i]) begin
                fails++; $display("FAIL %s_beat%0d: data=%0h last=%0b user=%0b required %0h %0b %0b",
                                  tag, i, q_data[i], q_last[i], q_user[i], e_data[i], e_last[i], e_user[i]);
            end
        end
        for (int i = 0; i < q_x.size() && i < e_x.size(); i++) begin
            tests_run++;
            if (q_x[i] !== e_x[i] || q_y[i] !== e_y[i]) begin
                fails++; $display("FAIL %s_coord%0d: x=%0h y=%0h required %0h %0h", tag, i, q_x[i], q_y[i], e_x[i], e_y[i]);
            end
        end
        tests_run++;
        if (n_stall_bad != 0 || n_start_bad != 0) begin
            fails++; $display("FAIL %s_stall: unstable=%0d starts_while_valid=%0d required 0 0", tag, n_stall_bad, n_start_bad);
        end
    endtask

    task automatic test_stall();
        core_lat = 2; stale_mode = 1'b0;
        test_stream_frame("stall", 3, 2, 2, 100, 1'b0);
    endtask

    task automatic test_stale_done();
        core_lat = 2; stale_mode = 1'b1;
        test_stream_frame("stale", 2, 2, 0, 100, 1'b0);
        stale_mode = 1'b0;
    endtask

    task automatic test_zero_dim();
        for (int k = 0; k < 2; k++) begin
            start_frame(k == 0 ? 0 : 3, k == 0 ? 2 : 0, 32'h1, 32'h2, 32'h3, 32'h4, 16'd9);
            run_frame(0, 100, 1'b0, 50);
            tests_run++;
            if (timeout || n_done != 1 || done_cycle < 0 || done_cycle > 1) begin
                fails++; $display("FAIL zero_dim%0d_done: pulses=%0d at=%0d timeout=%0b required 1 pulse within 2 cycles",
                                  k, n_done, done_cycle, timeout);
            end
            tests_run++;
            if (q_x.size() != 0 || q_data.size() != 0) begin
                fails++; $display("FAIL zero_dim%0d_activity: starts=%0d beats=%0d required 0 0", k, q_x.size(), q_data.size());
            end
        end
    endtask

    task automatic test_reset_midframe();
        int starts = 0, cyc = 0;
        core_lat = 6; stale_mode = 1'b0;
        start_frame(3, 2, 32'h00100000, 32'h00200000, 32'h00010000, 32'h00020000, 16'd50);
        m_tready = 1'b1;
        while (starts < 4 && cyc < 300) begin
            if (core_start) starts++;
            if (starts < 4) begin @(negedge clk); cyc++; end
        end
        tests_run++;
        if (starts < 4) begin
            fails++; $display("FAIL rst_mid_reach: starts=%0d required 4", starts);
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if ({busy, frame_done, core_start, m_tvalid, m_tlast, m_tuser} !== 6'b0) begin
            fails++; $display("FAIL rst_mid_ctrl: ctrl=%0b required 0", {busy, frame_done, core_start, m_tvalid, m_tlast, m_tuser});
        end
        tests_run++;
        if ({core_x0, core_y0, core_mi, m_tdata} !== '0) begin
            fails++; $display("FAIL rst_mid_data: data=%0h required 0", {core_x0, core_y0, core_mi, m_tdata});
        end
        @(negedge clk);
        rst = 1'b0; m_tready = 1'b0; core_lat = 2;
        test_stream_frame("rst_restart", 3, 2, 0, 100, 1'b0);
    endtask

    task automatic test_wrap_midstart();
        core_lat = 3; stale_mode = 1'b0;
        build_model(2, 1, 32'h7FFFFFFF, 32'h0, 32'h7FFFFFFF, 32'h0);
        start_frame(2, 1, 32'h7FFFFFFF, 32'h0, 32'h7FFFFFFF, 32'h0, 16'd7);
        run_frame(0, 100, 1'b1, 500);
        tests_run++;
        if (q_x.size() != 2 || q_x[q_x.size() > 1 ? 1 : 0] !== 32'hFFFFFFFE) begin
            fails++; $display("FAIL wrap_x: starts=%0d second=%0h required 2 fffffffe",
                              q_x.size(), q_x.size() > 1 ? q_x[1] : 32'h0);
        end
        tests_run++;
        if (timeout || q_data.size() != 2 || n_done != 1) begin
            fails++; $display("FAIL wrap_frame: beats=%0d done=%0d required 2 1", q_data.size(), n_done);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL wrap_midstart_ignored: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            core_lat = $urandom_range(4, 1);
            stale_mode = $urandom_range(1);
            test_stream_frame("random", $urandom_range(4, 1), $urandom_range(3, 1), 0, 60, 1'b0);
        end
        stale_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_stall();
        test_stale_done();
        test_zero_dim();
        test_reset_midframe();
        test_wrap_midstart();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
